// File: rtl/memory_turn_ctrl.sv
// ============================================================================
// Module      : memory_turn_ctrl
// Description : Turn sequencer for a 4x4 memory (pairs) game. Takes the board
//               cursor, a select pulse and the card value under the cursor,
//               runs the two-pick reveal / compare / keep-or-hide sequence and
//               keeps score for the display stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high
//   sel        in   1  one-cycle select pulse (debounced upstream)
//   cur_x      in   2  cursor column
//   cur_y      in   2  cursor row
//   card_val   in   3  board value at (cur_y,cur_x), valid with sel
//   revealed   out 16  face-up mask, bit = cur_y*4+cur_x (includes matched)
//   matched    out 16  permanently matched mask
//   pairs      out  4  matched-pair count 0..8
//   attempts   out  8  completed turns, saturating at 255
//   mismatch   out  1  high while a wrong pair is on display
//   game_over  out  1  high once all 8 pairs are matched
// ============================================================================
`default_nettype none

module memory_turn_ctrl #(
    parameter int HIDE_CYCLES = 50_000_000,
    parameter int TMR_W       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  cur_x,
    input  logic [1:0]  cur_y,
    input  logic [2:0]  card_val,
    output logic [15:0] revealed,
    output logic [15:0] matched,
    output logic [3:0]  pairs,
    output logic [7:0]  attempts,
    output logic        mismatch,
    output logic        game_over
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_PICK1 = 3'd0;
    localparam logic [2:0] ST_PICK2 = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_SHOW  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Timer reload value: the pair is cleared on the cycle the timer reads 0,
    // so loading HIDE_CYCLES-1 gives exactly HIDE_CYCLES cycles of display.
    localparam logic [TMR_W-1:0] C_HIDE_LOAD = TMR_W'(HIDE_CYCLES - 1);
    localparam logic [3:0]       C_LAST_PAIR = 4'd7;
    localparam logic [7:0]       C_ATT_MAX   = 8'hFF;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [3:0]        r_idx1;
    logic [3:0]        r_idx2;
    logic [2:0]        r_val1;
    logic [2:0]        r_val2;
    logic [15:0]       r_revealed;
    logic [15:0]       r_matched;
    logic [3:0]        r_pairs;
    logic [7:0]        r_attempts;
    logic              r_mismatch;
    logic              r_game_over;
    logic [TMR_W-1:0]  r_timer;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [2:0]  w_state_next;
    logic [3:0]  w_idx;
    logic        w_sel_valid;
    logic [15:0] w_pick_bit;
    logic [15:0] w_pair_mask;
    logic        w_pair_equal;
    logic        w_last_pair;
    logic        w_timer_zero;
    logic [7:0]  w_attempts_inc;

    assign w_idx        = {cur_y, cur_x};
    // A card already face-up (including matched cards and the first pick of
    // this turn) cannot be picked; such a select is simply dropped.
    assign w_sel_valid  = sel & ~r_revealed[w_idx];
    assign w_pick_bit   = 16'd1 << w_idx;
    assign w_pair_mask  = (16'd1 << r_idx1) | (16'd1 << r_idx2);
    assign w_pair_equal = (r_val1 == r_val2);
    assign w_last_pair  = (r_pairs == C_LAST_PAIR);
    assign w_timer_zero = (r_timer == '0);
    assign w_attempts_inc = (r_attempts == C_ATT_MAX) ? C_ATT_MAX
                                                      : r_attempts + 8'd1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_PICK1: begin
                if (w_sel_valid) begin
                    w_state_next = ST_PICK2;
                end
            end
            ST_PICK2: begin
                if (w_sel_valid) begin
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_pair_equal) begin
                    w_state_next = w_last_pair ? ST_DONE : ST_PICK1;
                end else begin
                    w_state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_timer_zero) begin
                    w_state_next = ST_PICK1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_PICK1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_PICK1;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Pick capture: card positions and values of the current turn
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx1 <= 4'd0;
            r_val1 <= 3'd0;
            r_idx2 <= 4'd0;
            r_val2 <= 3'd0;
        end else begin
            if (r_state == ST_PICK1 && w_sel_valid) begin
                r_idx1 <= w_idx;
                r_val1 <= card_val;
            end
            if (r_state == ST_PICK2 && w_sel_valid) begin
                r_idx2 <= w_idx;
                r_val2 <= card_val;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Face-up mask: set on each valid pick, the mismatched pair is turned
    // back over when the display timer expires.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_revealed <= 16'd0;
        end else begin
            case (r_state)
                ST_PICK1, ST_PICK2: begin
                    if (w_sel_valid) begin
                        r_revealed <= r_revealed | w_pick_bit;
                    end
                end
                ST_SHOW: begin
                    if (w_timer_zero) begin
                        r_revealed <= r_revealed & ~w_pair_mask;
                    end
                end
                default: begin
                    r_revealed <= r_revealed;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Scoring: only the CHECK cycle updates matched/pairs/attempts/game_over
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_matched   <= 16'd0;
            r_pairs     <= 4'd0;
            r_attempts  <= 8'd0;
            r_game_over <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_attempts <= w_attempts_inc;
            if (w_pair_equal) begin
                r_matched <= r_matched | w_pair_mask;
                r_pairs   <= r_pairs + 4'd1;
                if (w_last_pair) begin
                    r_game_over <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Mismatch display timer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer    <= '0;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                ST_CHECK: begin
                    if (!w_pair_equal) begin
                        r_timer    <= C_HIDE_LOAD;
                        r_mismatch <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (w_timer_zero) begin
                        r_mismatch <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_timer    <= r_timer;
                    r_mismatch <= r_mismatch;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign revealed  = r_revealed;
    assign matched   = r_matched;
    assign pairs     = r_pairs;
    assign attempts  = r_attempts;
    assign mismatch  = r_mismatch;
    assign game_over = r_game_over;

endmodule

`default_nettype wire
